// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: default widths,
// scoreboard stage indices and the per-stage entry layout.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int DEPTH  = 2;

    localparam int SB_EXE = 0;
    localparam int SB_MEM = 1;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Compares one ID source register against every tracked in-flight write
// and flags a read-after-write conflict.
module sb_match #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic [REG_AW-1:0]       src,
    input  logic                    used,
    input  logic [DEPTH-1:0]        v,
    input  logic [DEPTH*REG_AW-1:0] dest,
    output logic                    match
);

    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v[i] && (dest[i*REG_AW +: REG_AW] == src)) begin
                hit = 1'b1;
            end
        end
    end

    // r0 is hard-wired to zero, so reading it can never conflict.
    assign match = used && (src != '0) && hit;

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall controller: shift-register scoreboard of in-flight writes in EXE/MEM,
// combinational freeze for RAW hazards in ID, and a saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = hazard_pkg::REG_AW,
    parameter int DEPTH  = hazard_pkg::DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              flush,
    output logic              freez,
    output logic [1:0]        hazard_src,
    output logic [DEPTH-1:0]  pending,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DEPTH-1:0]        sb_v;
    logic [REG_AW-1:0]       sb_dest [DEPTH];
    logic [DEPTH*REG_AW-1:0] dest_flat;
    logic                    match1;
    logic                    match2;
    logic                    ins_v;

    always_comb begin
        dest_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dest_flat[i*REG_AW +: REG_AW] = sb_dest[i];
        end
    end

    sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_match1 (
        .src   (id_src1),
        .used  (id_src1_used),
        .v     (sb_v),
        .dest  (dest_flat),
        .match (match1)
    );

    sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_match2 (
        .src   (id_src2),
        .used  (id_src2_used),
        .v     (sb_v),
        .dest  (dest_flat),
        .match (match2)
    );

    // NOTE: rst gates freez combinationally so the stall drops in the reset cycle itself, not one later.
    assign freez      = ~rst & id_valid & ~flush & (match1 | match2);
    assign hazard_src = {match2, match1} & {2{freez}};
    assign pending    = sb_v;

    // A stalled or wrong-path ID instruction enters the scoreboard as a bubble.
    assign ins_v = id_valid & id_wb_en & (id_dest != '0) & ~freez & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every entry shifts from its pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v      <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sb_dest[i] <= '0;
            end
        end else begin
            sb_v[SB_EXE]    <= ins_v;
            sb_dest[SB_EXE] <= id_dest;
            for (int i = SB_MEM; i < DEPTH; i++) begin
                sb_v[i]    <= sb_v[i-1];
                sb_dest[i] <= sb_dest[i-1];
            end
            if (freez && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected freez/hazard_src per cycle
// are queued when an ID instruction is driven and popped at the sampling edge.
module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;

    typedef struct {
        logic       freez;
        logic [1:0] hsrc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic              id_src1_used;
    logic [REG_AW-1:0] id_src2;
    logic              id_src2_used;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              flush;
    logic              freez;
    logic [1:0]        hazard_src;
    logic [DEPTH-1:0]  pending;
    logic [CNT_W-1:0]  stall_cnt;

    exp_t       exp_q[$];
    logic [3:0] exp_cnt;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src1_used (id_src1_used),
        .id_src2      (id_src2),
        .id_src2_used (id_src2_used),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .flush        (flush),
        .freez        (freez),
        .hazard_src   (hazard_src),
        .pending      (pending),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds one instruction in ID for (stalls + 1) cycles, checking freez and
    // hazard_src each cycle; hs0/hs1 are the conflicts expected on stall cycles 0/1.
    task automatic issue(input string tag, input logic vld,
                         input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2,
                         input logic [4:0] d, input logic wb, input logic fl,
                         input int stalls, input logic [1:0] hs0, input logic [1:0] hs1);
        exp_t e;
        exp_t got;
        id_valid     = vld;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_src2_used = u2;
        id_dest      = d;
        id_wb_en     = wb;
        flush        = fl;
        for (int k = 0; k <= stalls; k++) begin
            e.freez = (k < stalls);
            e.hsrc  = (k >= stalls) ? 2'b00 : ((k == 0) ? hs0 : hs1);
            exp_q.push_back(e);
            @(negedge clk);
            got = exp_q.pop_front();
            chk({tag, ".freez"}, 32'(freez), 32'(got.freez));
            chk({tag, ".hsrc"}, 32'(hazard_src), 32'(got.hsrc));
            if (got.freez && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) begin
            issue("nop", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 2'b00, 2'b00);
        end
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b1; id_src1 = 5'd3; id_src1_used = 1'b1;
        id_src2 = 5'd4; id_src2_used = 1'b1; id_dest = 5'd3; id_wb_en = 1'b1; flush = 1'b0;
        exp_cnt = 4'd0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.freez", 32'(freez), 32'd0);
        chk("rst.hsrc", 32'(hazard_src), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("rst.pending", 32'(pending), 32'd0);
        chk("rst.cnt", 32'(stall_cnt), 32'd0);

        // back-to-back: ADD r3 = r1 + r2; SUB r5 = r3 - r1
        issue("b2b.add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        chk("b2b.pending", 32'(pending), 32'b01);
        issue("b2b.sub", 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 2, 2'b01, 2'b01);
        chk("b2b.cnt", 32'(stall_cnt), 32'd2);
        nop(2);

        // one-instruction gap: ADD r3; ADDI r7 = r1 + imm; AND r8 = r1 & r3
        issue("gap1.add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("gap1.addi", 1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("gap1.and", 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1, 2'b10, 2'b00);
        chk("gap1.cnt", 32'(stall_cnt), 32'(exp_cnt));
        nop(2);

        // two-instruction gap: no stall
        issue("gap2.add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("gap2.addi1", 1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("gap2.addi2", 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("gap2.and", 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        nop(2);

        // r0 destination and sources never conflict
        issue("r0.addi", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        chk("r0.pending", 32'(pending), 32'b00);
        issue("r0.add", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        nop(2);

        // unused rt that names an in-flight dest
        issue("unused.addi6", 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 5'd6, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("unused.addi9", 1'b1, 5'd2, 1'b1, 5'd6, 1'b0, 5'd9, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        nop(2);

        // both sources match different entries: MEM=r3, EXE=r4
        issue("both.add3", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("both.add4", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("both.sub", 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 2, 2'b11, 2'b10);
        chk("both.cnt", 32'(stall_cnt), 32'(exp_cnt));
        nop(2);

        // flush beats a hazard; the older r4 write keeps advancing into MEM
        issue("flush.add3", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("flush.add4", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        issue("flush.sub", 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 0, 2'b00, 2'b00);
        chk("flush.pending", 32'(pending), 32'b10);
        issue("flush.target", 1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1, 2'b01, 2'b00);
        nop(2);

        // reset during the first stall cycle
        issue("rstmid.add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        id_src1 = 5'd3; id_src2 = 5'd1; id_dest = 5'd5;
        @(negedge clk);
        chk("rstmid.stall", 32'(freez), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.freez_now", 32'(freez), 32'd0);
        @(posedge clk); #1;
        chk("rstmid.freez_rst", 32'(freez), 32'd0);
        chk("rstmid.hsrc_rst", 32'(hazard_src), 32'd0);
        rst = 1'b0;
        exp_cnt = 4'd0;
        #1;
        chk("rstmid.freez", 32'(freez), 32'd0);
        chk("rstmid.pending", 32'(pending), 32'b00);
        chk("rstmid.cnt", 32'(stall_cnt), 32'd0);
        nop(2);

        // saturation: ten dependent pairs give 20 stall cycles on a 4-bit counter
        for (int p = 0; p < 10; p++) begin
            issue("sat.add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
            issue("sat.sub", 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 2, 2'b01, 2'b01);
            if (p == 7) chk("sat.reach", 32'(stall_cnt), 32'd15);
        end
        chk("sat.hold", 32'(stall_cnt), 32'd15);
        chk("sat.model", 32'(stall_cnt), 32'(exp_cnt));
        nop(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Stall controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB). It tracks in-flight register writes in a shift-register scoreboard and raises `freez` when the instruction in ID reads a register that an older in-flight instruction has not yet written. `freez` gates the ID control outputs and holds IF/PC. The block also honours the branch flush from EXE and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- `REG_AW`, 5, register-index width.
- `DEPTH`, 2, number of tracked stages (EXE, MEM). The WB write lands on negedge before ID reads, so WB is not tracked.
- `CNT_W`, 16, stall-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real (non-bubble) instruction.
- `id_src1`  in  REG_AW  rs field, `instruction[25:21]`.
- `id_src1_used`  in  1  rs is read by this opcode.
- `id_src2`  in  REG_AW  rt field, `instruction[20:16]`.
- `id_src2_used`  in  1  rt is read as a register (controller `isSrc2`).
- `id_dest`  in  REG_AW  destination selected by the ID dest mux.
- `id_wb_en`  in  1  undecoded controller WB enable.
- `flush`  in  1  taken branch or jump resolved in EXE.
- `freez`  out  1  stall: ID emits a bubble, IF and PC hold.
- `hazard_src`  out  2  bit0 = src1 conflict, bit1 = src2 conflict (qualified by `freez`).
- `pending`  out  DEPTH  valid bits of the scoreboard stages; bit0 = EXE.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `freez` = 1.

## Operation
- Scoreboard entry `i` holds `{v, dest}` for the instruction now in stage `i` (0 = EXE, 1 = MEM).
- Match condition for a source `s`: `used && s != 0 && v[i] && dest[i] == s`, for any `i`.
- `freez = id_valid & ~flush & (match1 | match2)`. This path is combinational, with no latency.
- Insert value at posedge:
  - `v = id_valid & id_wb_en & (id_dest != 0) & ~freez & ~flush`
  - `dest = id_dest`
  - The value enters entry 0; entry `i` shifts to entry `i+1`; the last entry is dropped.
- On `freez`, a bubble (`v` = 0) enters entry 0 and the older entries keep advancing. The hazard therefore clears once the producer passes the last tracked stage.
- On `flush`, the ID instruction is wrong-path:
  - it is not inserted and does not stall;
  - older entries (EXE, MEM) are kept, because the branch itself has no dest.
- Register 0 never creates a hazard, either as a source or as a destination.
- `stall_cnt` increments on every posedge where `freez` = 1 and stops at all-ones (no wrap).
- `hazard_src` = `{match2, match1} & {2{freez}}`.

## Timing
- Reset (`rst` high at posedge): all `v` = 0, all `dest` = 0, `stall_cnt` = 0.
- While `rst` is high, force `freez` = 0 and `hazard_src` = 0. After reset, `pending` = 0.
- Reset mid-stall: the stall drops at the first posedge where `rst` is high and stays dropped.
- Producer-to-consumer spacing:
  - Back-to-back dependent pair: 2 stall cycles.
  - One independent instruction between them: 1 stall cycle.
  - Two or more between them: 0 stall cycles.
- LD has the same spacing as ALU ops, since memory read is complete in MEM.
- `flush` and a hazard in the same cycle: `flush` wins, `freez` = 0, no insert.
- Both sources matching different entries: a single `freez`, and `hazard_src` = 2'b11.
- Saturation: `stall_cnt` = all-ones stays there while `freez` = 1.

## Structure
- Shared package `hazard_pkg` holds:
  - `REG_AW`, `DEPTH`;
  - the stage-index constants `SB_EXE` = 0 and `SB_MEM` = 1;
  - the entry struct/typedef `{v, dest}`.
- One sub-module, `sb_match`: compares one source (`src`, `used`) against all `DEPTH` entries and returns a 1-bit match. It is instantiated twice.
- Top-level pipeline glue:
  - drives IF PC hold and the IF/ID hold from `freez`;
  - feeds `freez` into the existing ID control-zeroing.

## Test plan
- Hazard on the immediate predecessor: ADD r3 then SUB r5 = r3 - r1 → `freez` = 1 for exactly 2 cycles, `hazard_src` = 01, `stall_cnt` = 2, SUB proceeds on cycle 3.
- One-instruction gap: ADD r3; ADDI r7; AND r8 = r1 & r3 → 1 stall cycle, `hazard_src` = 10. Two-instruction gap → 0 stalls.
- Register 0 and unused sources:
  - ADDI r0 then ADD r4 = r0 + r0 → no stall.
  - ADDI r6 then ADDI r9 = r2 + imm (rt = 6, `id_src2_used` = 0) → no stall.
- Flush precedence: hazard condition present with `flush` = 1 in the same cycle → `freez` = 0, `pending[0]` = 0 next cycle, MEM entry preserved.
- Reset during stall: assert `rst` on the 1st stall cycle → next cycle `freez` = 0, `pending` = 00, `stall_cnt` = 0.
- Saturation: `CNT_W` = 4, hold a hazard (force entries) for 20 cycles → `stall_cnt` reaches 15 and stays at 15.
